// File: rtl/deep_pkg.sv
// Shared definitions for the network: layer geometry, weight-memory
// address width and the weight_server state encoding.
package deep_pkg;

    localparam int L0_WORDS = 128;                 // hidden-layer width
    localparam int L0_ROWS  = 784;                 // one row per input pixel
    localparam int L1_WORDS = 10;                  // output classes
    localparam int L1_ROWS  = 128;                 // one row per hidden neuron
    localparam int L0_BASE  = 0;                   // word address of layer-0 row 0
    localparam int L1_BASE  = L0_ROWS * L0_WORDS;  // layer-1 rows follow layer 0
    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 32;

    typedef enum logic [2:0] {
        WS_IDLE   = 3'd0,
        WS_FETCH0 = 3'd1,
        WS_FETCH1 = 3'd2,
        WS_DONE0  = 3'd3,
        WS_DONE1  = 3'd4
    } ws_state_t;

endpackage

// File: rtl/ws_row_fetch.sv
// Row fetch engine: issues `count` sequential reads starting at `base` and
// produces a capture strobe/index delayed by one cycle so it lines up with
// the synchronous-read data. `last` marks the capture of the final word.
module ws_row_fetch #(
    parameter int ADDR_W = 17,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [IDX_W:0]    count,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic [IDX_W-1:0]  cap_idx,
    output logic              cap_stb,
    output logic              last
);

    localparam logic [IDX_W:0] ONE = 1;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  lidx_q, lidx_d;
    logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
    logic              cap_stb_q, cap_stb_d;
    logic              last_q, last_d;
    logic [IDX_W:0]    count_m1;
    logic              k_is_last;

    // Next-state for the issue pointer and the one-cycle-delayed capture pointer.
    always_comb begin
        count_m1  = count - ONE;
        k_is_last = (k_q == lidx_q);
        addr_d    = addr_q;
        rd_d      = rd_q;
        k_d       = k_q;
        lidx_d    = lidx_q;
        cap_stb_d = rd_q;
        cap_idx_d = k_q;
        last_d    = rd_q && k_is_last;
        if (start) begin
            rd_d   = 1'b1;
            addr_d = base;
            k_d    = '0;
            lidx_d = count_m1[IDX_W-1:0];
        end else if (rd_q) begin
            if (k_is_last) begin
                // Address is left on the last word once reading stops.
                rd_d = 1'b0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                k_d    = k_q + IDX_W'(1);
            end
        end
    end

    // Engine registers; reset aborts any read sequence in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q    <= '0;
            rd_q      <= 1'b0;
            k_q       <= '0;
            lidx_q    <= '0;
            cap_idx_q <= '0;
            cap_stb_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            k_q       <= k_d;
            lidx_q    <= lidx_d;
            cap_idx_q <= cap_idx_d;
            cap_stb_q <= cap_stb_d;
            last_q    <= last_d;
        end
    end

    assign addr    = addr_q;
    assign rd      = rd_q;
    assign cap_idx = cap_idx_q;
    assign cap_stb = cap_stb_q;
    assign last    = last_q;

endmodule

// File: rtl/weight_server.sv
// Weight server: on a start_n pulse, streams the next row of layer-n weights
// from the weight memory into values_n and pulses valid_n when complete.
//
// Handshake: start_n is a one-cycle request pulse with no ready; a request
// seen while busy is remembered in a single pending flag per layer (repeats
// collapse). valid_n is a one-cycle pulse; values_n is stable from that
// cycle until the next fetch of the same layer starts.
module weight_server
    import deep_pkg::ws_state_t;
    import deep_pkg::WS_IDLE;
    import deep_pkg::WS_FETCH0;
    import deep_pkg::WS_FETCH1;
    import deep_pkg::WS_DONE0;
    import deep_pkg::WS_DONE1;
#(
    parameter int L0_WORDS = deep_pkg::L0_WORDS,
    parameter int L0_ROWS  = deep_pkg::L0_ROWS,
    parameter int L1_WORDS = deep_pkg::L1_WORDS,
    parameter int L1_ROWS  = deep_pkg::L1_ROWS,
    parameter int L0_BASE  = deep_pkg::L0_BASE,
    parameter int L1_BASE  = deep_pkg::L1_BASE,
    parameter int ADDR_W   = deep_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_0,
    input  logic                      start_1,
    input  logic                      row_clr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd,
    input  logic [31:0]               mem_rdata,
    output logic [L0_WORDS-1:0][31:0] values_0,
    output logic [L1_WORDS-1:0][31:0] values_1,
    output logic                      valid_0,
    output logic                      valid_1,
    output logic                      busy,
    output ws_state_t                 dbg_state
);

    localparam int MAX_WORDS = (L0_WORDS > L1_WORDS) ? L0_WORDS : L1_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS);
    localparam int R0_W      = $clog2(L0_ROWS);
    localparam int R1_W      = $clog2(L1_ROWS);

    ws_state_t                 state_q;
    logic                      busy_q;
    logic                      valid_0_q, valid_1_q;
    logic                      pend_0_q, pend_0_d;
    logic                      pend_1_q, pend_1_d;
    logic [R0_W-1:0]           row_0_q, row_0_d, row_0_eff;
    logic [R1_W-1:0]           row_1_q, row_1_d, row_1_eff;
    logic                      clr_hit_q, clr_hit_d;
    logic [L0_WORDS-1:0][31:0] values_0_q, values_0_d;
    logic [L1_WORDS-1:0][31:0] values_1_q, values_1_d;

    logic                      is_idle, go_0, go_1, launch;
    logic [ADDR_W-1:0]         fetch_base;
    logic [IDX_W:0]            fetch_count;
    logic [ADDR_W-1:0]         eng_addr;
    logic                      eng_rd;
    logic [IDX_W-1:0]          cap_idx;
    logic                      cap_stb, cap_last;

    // Arbitration in IDLE (layer 0 always first) and the row base address.
    always_comb begin
        is_idle   = (state_q == WS_IDLE);
        go_0      = is_idle && (start_0 || pend_0_q);
        go_1      = is_idle && !go_0 && (start_1 || pend_1_q);
        launch    = go_0 || go_1;
        row_0_eff = row_clr ? '0 : row_0_q;
        row_1_eff = row_clr ? '0 : row_1_q;
        if (go_0) begin
            fetch_base  = ADDR_W'(L0_BASE) + ADDR_W'(row_0_eff) * ADDR_W'(L0_WORDS);
            fetch_count = (IDX_W+1)'(L0_WORDS);
        end else begin
            fetch_base  = ADDR_W'(L1_BASE) + ADDR_W'(row_1_eff) * ADDR_W'(L1_WORDS);
            fetch_count = (IDX_W+1)'(L1_WORDS);
        end
    end

    // Pending flags, row counters and the "row_clr seen mid-fetch" marker.
    // A clear that lands during a fetch must also cancel that fetch's
    // DONE-cycle increment, otherwise the next row would be 1 instead of 0.
    always_comb begin
        pend_0_d = pend_0_q;
        pend_1_d = pend_1_q;
        if (is_idle) begin
            if (go_0) begin
                pend_0_d = 1'b0;
                pend_1_d = pend_1_q || start_1;
            end else if (go_1) begin
                pend_1_d = 1'b0;
            end
        end else begin
            pend_0_d = pend_0_q || start_0;
            pend_1_d = pend_1_q || start_1;
        end

        row_0_d = row_0_q;
        row_1_d = row_1_q;
        if (state_q == WS_DONE0 && !clr_hit_q) begin
            row_0_d = (row_0_q == R0_W'(L0_ROWS - 1)) ? '0 : row_0_q + R0_W'(1);
        end
        if (state_q == WS_DONE1 && !clr_hit_q) begin
            row_1_d = (row_1_q == R1_W'(L1_ROWS - 1)) ? '0 : row_1_q + R1_W'(1);
        end

        clr_hit_d = clr_hit_q;
        if ((state_q == WS_FETCH0 || state_q == WS_FETCH1) && row_clr) begin
            clr_hit_d = 1'b1;
        end else if (state_q == WS_DONE0 || state_q == WS_DONE1) begin
            clr_hit_d = 1'b0;
        end

        if (row_clr) begin
            pend_0_d = 1'b0;
            pend_1_d = 1'b0;
            row_0_d  = '0;
            row_1_d  = '0;
        end
    end

    // In-place slot capture into the bus of the layer being fetched.
    always_comb begin
        values_0_d = values_0_q;
        values_1_d = values_1_q;
        if (cap_stb && state_q == WS_FETCH0) begin
            for (int i = 0; i < L0_WORDS; i++) begin
                if (cap_idx == IDX_W'(i)) values_0_d[i] = mem_rdata;
            end
        end
        if (cap_stb && state_q == WS_FETCH1) begin
            for (int i = 0; i < L1_WORDS; i++) begin
                if (cap_idx == IDX_W'(i)) values_1_d[i] = mem_rdata;
            end
        end
    end

    // Control FSM with registered busy/valid outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= WS_IDLE;
            busy_q    <= 1'b0;
            valid_0_q <= 1'b0;
            valid_1_q <= 1'b0;
        end else begin
            valid_0_q <= 1'b0;
            valid_1_q <= 1'b0;
            case (state_q)
                WS_IDLE: begin
                    if (go_0) begin
                        state_q <= WS_FETCH0;
                        busy_q  <= 1'b1;
                    end else if (go_1) begin
                        state_q <= WS_FETCH1;
                        busy_q  <= 1'b1;
                    end
                end
                WS_FETCH0: begin
                    if (cap_stb && cap_last) begin
                        state_q   <= WS_DONE0;
                        valid_0_q <= 1'b1;
                    end
                end
                WS_FETCH1: begin
                    if (cap_stb && cap_last) begin
                        state_q   <= WS_DONE1;
                        valid_1_q <= 1'b1;
                    end
                end
                WS_DONE0, WS_DONE1: begin
                    state_q <= WS_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= WS_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bookkeeping and row-bus registers; reset also wipes partial rows.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_0_q   <= 1'b0;
            pend_1_q   <= 1'b0;
            row_0_q    <= '0;
            row_1_q    <= '0;
            clr_hit_q  <= 1'b0;
            values_0_q <= '0;
            values_1_q <= '0;
        end else begin
            pend_0_q   <= pend_0_d;
            pend_1_q   <= pend_1_d;
            row_0_q    <= row_0_d;
            row_1_q    <= row_1_d;
            clr_hit_q  <= clr_hit_d;
            values_0_q <= values_0_d;
            values_1_q <= values_1_d;
        end
    end

    ws_row_fetch #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_fetch (
        .clk     (clk),
        .rst     (rst),
        .start   (launch),
        .base    (fetch_base),
        .count   (fetch_count),
        .addr    (eng_addr),
        .rd      (eng_rd),
        .cap_idx (cap_idx),
        .cap_stb (cap_stb),
        .last    (cap_last)
    );

    assign mem_addr  = eng_addr;
    assign mem_rd    = eng_rd;
    assign values_0  = values_0_q;
    assign values_1  = values_1_q;
    assign valid_0   = valid_0_q;
    assign valid_1   = valid_1_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_weight_server.sv
// Bench for weight_server: directed request sequences, a memory returning
// its own address, and a timeline model of fetches checked every cycle.
module tb_weight_server;
  import deep_pkg::*;

  localparam int W0 = 128;
  localparam int W1 = 10;
  localparam int B1 = 100352;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_0 = 1'b0, start_1 = 1'b0, row_clr = 1'b0;
  logic [16:0] mem_addr;
  logic mem_rd;
  logic [31:0] mem_rdata = '0;
  logic [W0-1:0][31:0] values_0;
  logic [W1-1:0][31:0] values_1;
  logic valid_0, valid_1, busy;
  ws_state_t dbg_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory with one-cycle read latency, mem[a] = a
  always @(posedge clk) if (mem_rd) mem_rdata <= 32'(mem_addr);

  weight_server dut (
    .clk(clk), .rst(rst), .start_0(start_0), .start_1(start_1), .row_clr(row_clr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .values_0(values_0), .values_1(values_1),
    .valid_0(valid_0), .valid_1(valid_1), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- model ----------------
  typedef struct { int layer; int t; int row; } rec_t;
  rec_t recs[$];
  int last0 = -1, last1 = -1;   // row currently expected on each bus, -1 = zeros
  int m_row0 = 0, m_row1 = 0;
  bit chk_en = 1'b0;
  int n_vec = 0, n_fail = 0;

  function automatic logic [31:0] exp_word(int layer, int row, int k);
    if (row < 0) return 32'd0;
    if (layer == 0) return 32'(row * W0 + k);
    return 32'(B1 + row * W1 + k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_bus0(input string nm);
    int bad = -1;
    for (int k = 0; k < W0; k++)
      if (bad < 0 && values_0[k] !== exp_word(0, last0, k)) bad = k;
    n_vec++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: values_0[%0d] = %0d, expected %0d",
               nm, cyc, bad, values_0[bad], exp_word(0, last0, bad));
    end
  endtask

  task automatic chk_bus1(input string nm);
    int bad = -1;
    for (int k = 0; k < W1; k++)
      if (bad < 0 && values_1[k] !== exp_word(1, last1, k)) bad = k;
    n_vec++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: values_1[%0d] = %0d, expected %0d",
               nm, cyc, bad, values_1[bad], exp_word(1, last1, bad));
    end
  endtask

  // one fetch record: request sampled in cycle t -> rd t+1..t+W,
  // busy t+1..t+W+2, valid at t+W+2, bus in flux t+2..t+W+1
  task automatic compare_cycle();
    bit e_busy = 0, e_rd = 0, e_v0 = 0, e_v1 = 0, chg0 = 0, chg1 = 0;
    int e_addr = 0;
    rec_t keep[$];
    foreach (recs[i]) begin
      int w = (recs[i].layer == 0) ? W0 : W1;
      int base = (recs[i].layer == 0) ? recs[i].row * W0 : B1 + recs[i].row * W1;
      int d = cyc - recs[i].t;
      if (d >= 1 && d <= w + 2) e_busy = 1;
      if (d >= 1 && d <= w) begin e_rd = 1; e_addr = base + d - 1; end
      if (d >= 2 && d <= w + 1) begin
        if (recs[i].layer == 0) chg0 = 1; else chg1 = 1;
      end
      if (d == w + 2) begin
        if (recs[i].layer == 0) begin e_v0 = 1; last0 = recs[i].row; end
        else begin e_v1 = 1; last1 = recs[i].row; end
      end
      if (d < w + 2) keep.push_back(recs[i]);
    end
    recs = keep;
    chk("busy", busy, e_busy);
    chk("mem_rd", mem_rd, e_rd);
    if (e_rd) chk("mem_addr", mem_addr, e_addr);
    chk("valid_0", valid_0, e_v0);
    chk("valid_1", valid_1, e_v1);
    if (!chg0) chk_bus0("values_0");
    if (!chg1) chk_bus1("values_1");
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) if (chk_en) compare_cycle();

  // ---------------- driver tasks ----------------
  task automatic go(input bit s0, input bit s1, output int t);
    @(posedge clk); #1;
    start_0 = s0; start_1 = s1; t = cyc;
    @(posedge clk); #1;
    start_0 = 1'b0; start_1 = 1'b0;
  endtask

  task automatic push(input int layer, input int t, input int row);
    rec_t r;
    r.layer = layer; r.t = t; r.row = row;
    recs.push_back(r);
  endtask

  task automatic fetch0(output int t);
    go(1'b1, 1'b0, t);
    push(0, t, m_row0);
    m_row0 = (m_row0 + 1) % 784;
  endtask

  task automatic fetch1(output int t);
    go(1'b0, 1'b1, t);
    push(1, t, m_row1);
    m_row1 = (m_row1 + 1) % 128;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; row_clr = 1'b1;
    m_row0 = 0; m_row1 = 0;
    @(posedge clk); #1; row_clr = 1'b0;
  endtask

  // bounded wait for a valid pulse; returns its latency from t0
  task automatic wait_valid(input int layer, input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((layer == 0 ? valid_0 : valid_1) === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++; n_fail++;
      $display("FAIL valid_%0d timeout: no pulse within 300 cycles of cyc %0d", layer, t0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, lat;

    // reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst valid_0", valid_0, 0);
    chk("rst valid_1", valid_1, 0);
    chk("rst mem_rd", mem_rd, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst state", dbg_state, WS_IDLE);
    chk_bus0("rst values_0");
    chk_bus1("rst values_1");
    rst = 1'b1;
    chk_en = 1'b1;

    // single layer-0 fetches: rows 0 and 1
    fetch0(t);
    wait_valid(0, t, lat);
    chk("l0 latency", lat, 130);
    chk("row0 w0", values_0[0], 0);
    chk("row0 w127", values_0[127], 127);
    fetch0(t);
    wait_valid(0, t, lat);
    chk("row1 w0", values_0[0], 128);
    chk("row1 w127", values_0[127], 255);

    // 129 layer-1 fetches: rows 0..127 then wrap to 0
    for (int i = 0; i < 129; i++) begin
      fetch1(t);
      wait_valid(1, t, lat);
      chk("l1 latency", lat, 12);
      if (i == 0) chk("l1 row0 w0", values_1[0], 100352);
      if (i == 127) chk("l1 row127 w9", values_1[9], 101631);
      if (i == 128) begin
        chk("l1 wrap w0", values_1[0], 100352);
        chk("l1 wrap w9", values_1[9], 100361);
      end
    end

    // collision: layer 0 served first, layer 1 one idle cycle after DONE0
    go(1'b1, 1'b1, t);
    push(0, t, m_row0); m_row0++;
    push(1, t + 131, m_row1); m_row1++;
    repeat (10) @(posedge clk);
    begin
      int t_drop;
      go(1'b0, 1'b1, t_drop);   // already pending: dropped
    end
    wait_valid(0, t, lat);
    chk("coll l0 latency", lat, 130);
    chk("coll row2 w0", values_0[0], 256);
    wait_valid(1, t, lat);
    chk("coll l1 latency", lat, 143);
    chk("coll l1 row1 w0", values_1[0], 100362);
    repeat (20) @(posedge clk);

    // row_clr: rows 0..4, clear mid-fetch of row 5, then row 0 again
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      fetch0(t);
      wait_valid(0, t, lat);
    end
    chk("row4 w0", values_0[0], 512);
    fetch0(t);
    repeat (40) @(posedge clk);
    pulse_clr();
    wait_valid(0, t, lat);
    chk("clr keeps row5 w0", values_0[0], 640);
    fetch0(t);
    wait_valid(0, t, lat);
    chk("after clr w0", values_0[0], 0);
    chk("after clr w1", values_0[1], 1);

    // reset at T+60 of a layer-0 fetch
    fetch0(t);
    while (cyc < t + 60) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    chk_en = 1'b0;
    recs.delete();
    last0 = -1; last1 = -1;
    m_row0 = 0; m_row1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst state", dbg_state, WS_IDLE);
    chk("midrst valid_0", valid_0, 0);
    chk("midrst busy", busy, 0);
    chk("midrst mem_rd", mem_rd, 0);
    chk_bus0("midrst values_0");
    chk_bus1("midrst values_1");
    rst = 1'b1;
    chk_en = 1'b1;
    fetch0(t);
    wait_valid(0, t, lat);
    chk("post rst latency", lat, 130);
    chk("post rst w1", values_0[1], 1);
    chk("post rst w127", values_0[127], 127);

    repeat (5) @(posedge clk);
    chk("records drained", recs.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_server.md
# weight_server

Responder side of the tile's weight-request handshake. On a `start_0` or `start_1` pulse from the tile, the block streams the next row of layer-0 or layer-1 weights out of an external synchronous-read weight memory (BRAM/ROM). It packs the row into the wide `values_0` / `values_1` buses and pulses `valid_0` / `valid_1` when the row is complete. It sits between `tile` and the weight BRAM inside the top-level network.

## Interface
Parameters:
- `L0_WORDS`, 128, words per layer-0 row (hidden-layer width)
- `L0_ROWS`, 784, layer-0 rows (one per input pixel)
- `L1_WORDS`, 10, words per layer-1 row (output classes)
- `L1_ROWS`, 128, layer-1 rows (one per hidden neuron)
- `L0_BASE`, 0, word address of layer-0 row 0
- `L1_BASE`, 100352, word address of layer-1 row 0 (= L0_ROWS*L0_WORDS)
- `ADDR_W`, 17, memory address width

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  synchronous, active-low reset
- `start_0`  in  1  request next layer-0 row (one-cycle pulse)
- `start_1`  in  1  request next layer-1 row (one-cycle pulse)
- `row_clr`  in  1  reset both row counters to 0 (new image)
- `mem_addr`  out  ADDR_W  weight memory word address
- `mem_rd`  out  1  memory read enable
- `mem_rdata`  in  32  read data, valid one cycle after `mem_rd`
- `values_0`  out  L0_WORDS x 32  layer-0 row, word i in slot i
- `values_1`  out  L1_WORDS x 32  layer-1 row
- `valid_0`, `valid_1`  out  1  one-cycle "row complete" pulses
- `busy`  out  1  fetch in progress

## Operation
- States: IDLE, FETCH0, FETCH1, DONE0, DONE1.
- IDLE to FETCH0 on a pending or new layer-0 request.
- IDLE to FETCH1 otherwise, on a pending or new layer-1 request.
- FETCH: issue `mem_rd`=1 with address `base + row*WORDS + k`, k = 0..WORDS-1. Capture `mem_rdata` into slot k one cycle later, using a delayed k and a delayed-valid flag.
- FETCHn to DONEn once the last word is captured.
- DONEn: pulse `valid_n`, increment `row_n` (wraps L0_ROWS-1 to 0, L1_ROWS-1 to 0), return to IDLE.
- Slots are written in place. `values_n` is only guaranteed coherent from the `valid_n` cycle until the next fetch of the same layer starts. The other layer's bus is never disturbed.
- Request latching:
  - One pending flag per layer.
  - A `start_n` arriving while busy sets `pend_n`. Repeats while already pending are dropped.
  - Simultaneous `start_0` and `start_1` in IDLE: layer 0 is served first and `pend_1` is set.
  - Priority in IDLE is always layer 0.
- `row_clr`: zeros both row counters and both pending flags.
  - If asserted during FETCH, the current fetch completes with its original row.
  - The DONE-cycle increment is suppressed when `row_clr` coincides with DONE.
- Address arithmetic: products computed in ADDR_W bits. Row counters are 10 bits (layer 0) and 7 bits (layer 1); no overflow for the default parameters.
- Reset values:
  - State IDLE.
  - `busy`, `valid_0`, `valid_1`, `mem_rd` all 0.
  - `mem_addr` 0.
  - `values_0` and `values_1` all zero.
  - Row counters, k, and pending flags 0.
- Reset mid-fetch aborts immediately. No `valid` is produced, and partially written slots are cleared.

## Timing
- `start_n` sampled in cycle T while in IDLE:
  - T+1 to T+WORDS: `mem_rd`=1, addresses sequential.
  - T+2 to T+WORDS+1: captures.
  - T+WORDS+2: DONE, with `valid_n` high for exactly one cycle.
- Latency from request to valid: layer 0 is 130 cycles, layer 1 is 12 cycles.
- `busy`=1 from T+1 through the DONE cycle inclusive.
- A pending request begins its fetch in the cycle after DONE, one IDLE cycle later. Back-to-back layer-0 rows therefore run at 131 cycles per row.
- `mem_rd` is 0 in IDLE and DONE. `mem_addr` holds its last value when not reading.
- All outputs are registered.

## Structure
- Shared package `deep_pkg`:
  - State enum `ws_state_t`.
  - Constants `L0_WORDS`, `L0_ROWS`, `L1_WORDS`, `L1_ROWS`, `L1_BASE`, `ADDR_W`, shared with `tile` and the top level.
- One sub-module, `ws_row_fetch`: the generic address-issue and capture-pointer engine (start, base, count in; addr, rd, capture index, capture strobe, last out). It is instantiated once and shared by both layers.
- The FSM, pending flags, row counters, and output registers live in `weight_server`.

## Test plan
All scenarios use a memory model with 1-cycle read latency where `mem[a] = a`.
- Reset: hold `rst`=0 for 3 cycles -> all outputs 0, `busy`=0; after release a `start_0` fetches row 0.
- Single layer-0 fetch: `start_0` at T -> `valid_0` at T+130; `values_0[k]` = k for k = 0..127; second `start_0` -> `values_0[k]` = 128+k.
- Layer-1 fetch and wrap: issue 129 `start_1` requests -> row 0 has `values_1[k]` = 100352+k; the 129th returns row 0 again; latency 12 each.
- Collision: `start_0` and `start_1` in the same cycle -> `valid_0` at T+130, `valid_1` at T+143; a third `start_1` during FETCH0 is dropped, so only one `valid_1`.
- `row_clr`: after 5 layer-0 rows, pulse `row_clr` during the 6th fetch -> 6th returns row 5 data; the next returns row 0 (`values_0[0]` = 0).
- Reset mid-fetch: drive `rst`=0 at T+60 of a layer-0 fetch -> no `valid_0`, `values_0` all zero, state IDLE; a new `start_0` fetches row 0.
